// File: rtl/disp_entry_buf_if.sv
// Key-entry buffer bus: scanner-side key inputs and display-side outputs.
// master drives keys and reads the display; slave is the buffer itself.
interface disp_entry_buf_if #(
    parameter int DIGITS = 8
);
    localparam int CW = $clog2(DIGITS + 1);

    logic                  nkpls;
    logic                  koff;
    logic [3:0]            bcds;
    logic                  clr;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  key_ack;
    logic                  ovf;

    modport master (
        output nkpls,
        output koff,
        output bcds,
        output clr,
        input  bcd_out,
        input  count,
        input  full,
        input  key_ack,
        input  ovf
    );

    modport slave (
        input  nkpls,
        input  koff,
        input  bcds,
        input  clr,
        output bcd_out,
        output count,
        output full,
        output key_ack,
        output ovf
    );
endinterface

// File: rtl/disp_entry_buf.sv
// Right-entry keypad display buffer with backspace, count, full/overflow.
// Optional LZ_SUPPRESS_EN: a leading 0 is shown but not counted.
module disp_entry_buf #(
    parameter int         DIGITS = 8,
    parameter logic [3:0] BLANK  = 4'hF,
    parameter logic [3:0] BKSP   = 4'hB
) (
    input  logic                   clk,
    input  logic                   rst,
    disp_entry_buf_if.slave        bus
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

`ifdef LZ_SUPPRESS_EN
    localparam bit LZ_SUP = 1'b1;
`else
    localparam bit LZ_SUP = 1'b0;
`endif

    logic                    s0_q;
    logic                    s1_q;
    logic                    s2_q;
    logic                    ev;

    logic [DIGITS-1:0][3:0]  dig_q;
    logic [DIGITS-1:0][3:0]  dig_d;
    logic [CW-1:0]           cnt_q;
    logic [CW-1:0]           cnt_d;
    logic                    ack_q;
    logic                    ack_d;
    logic                    ovf_q;
    logic                    ovf_d;

    logic                    is_bksp;
    logic                    is_digit;
    logic                    cnt_zero;
    logic                    cnt_full;
    logic                    lz_hold;

    // Strobe synchroniser; idles high so reset release never looks like a key.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s0_q <= bus.nkpls;
            s1_q <= s0_q;
            s2_q <= s1_q;
        end
    end

    assign ev       = ~s1_q & s2_q;
    assign is_bksp  = (bus.bcds == BKSP);
    assign is_digit = (bus.bcds <= 4'd9) && !is_bksp;
    assign cnt_zero = (cnt_q == '0);
    assign cnt_full = (cnt_q == CNT_MAX);
    assign lz_hold  = LZ_SUP && (bus.bcds == 4'd0);

    // Next display state: clear wins, then a valid key event.
    always_comb begin
        dig_d = dig_q;
        cnt_d = cnt_q;
        ack_d = 1'b0;
        ovf_d = 1'b0;
        if (bus.clr) begin
            for (int i = 0; i < DIGITS; i++) begin
                dig_d[i] = BLANK;
            end
            cnt_d = '0;
        end else if (ev && !bus.koff) begin
            if (is_bksp) begin
                ack_d = 1'b1;
                if (cnt_zero) begin
                    dig_d[0] = BLANK;
                end else begin
                    for (int i = 0; i < DIGITS - 1; i++) begin
                        dig_d[i] = dig_q[i+1];
                    end
                    dig_d[DIGITS-1] = BLANK;
                    cnt_d = cnt_q - CNT_ONE;
                end
            end else if (is_digit) begin
                if (cnt_full) begin
                    ovf_d = 1'b1;
                end else if (cnt_zero) begin
                    dig_d[0] = bus.bcds;
                    cnt_d    = lz_hold ? '0 : CNT_ONE;
                    ack_d    = 1'b1;
                end else begin
                    for (int i = 1; i < DIGITS; i++) begin
                        dig_d[i] = dig_q[i-1];
                    end
                    dig_d[0] = bus.bcds;
                    cnt_d    = cnt_q + CNT_ONE;
                    ack_d    = 1'b1;
                end
            end
        end
    end

    // Display, count and one-cycle status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                dig_q[i] <= BLANK;
            end
            cnt_q <= '0;
            ack_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            dig_q <= dig_d;
            cnt_q <= cnt_d;
            ack_q <= ack_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.bcd_out = dig_q;
    assign bus.count   = cnt_q;
    assign bus.full    = cnt_full;
    assign bus.key_ack = ack_q;
    assign bus.ovf     = ovf_q;
endmodule
